// File: rtl/mon_prod.sv
// mon_prod: radix-2 bit-serial Montgomery multiplier, P = A*B*2^-n mod M.
// Optional feature macro: MON_PROD_FINAL_SUB_EN
//   defined   -> extra SUB cycle performs the final conditional subtraction,
//                P is fully reduced into [0, M), latency n+2 edges.
//   undefined -> CALC finishes straight into DONE, P is in [0, 2M), latency n+1.
module mon_prod #(
  parameter int bitLen     = 64,
  parameter int wordLen    = 8,
  parameter int countWidth = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [bitLen-1:0]     A,
  input  logic [bitLen-1:0]     B,
  input  logic [bitLen-1:0]     M,
  input  logic [countWidth-1:0] num_words,
  output logic                  stop,
  output logic [bitLen-1:0]     P
);

  // Counter wide enough to hold the full iteration count bitLen.
  localparam int cnt_w = $clog2(bitLen + 1);
  // Two guard bits: S + B + M stays below 4*2^bitLen while S < 2M.
  localparam int s_w   = bitLen + 2;

  localparam logic [cnt_w-1:0] full_n = cnt_w'(bitLen);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SUB,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [bitLen-1:0] a_q;   // multiplicand, shifted right one bit per iteration
  logic [bitLen-1:0] b_q;
  logic [bitLen-1:0] m_q;
  logic [s_w-1:0]    s_q;   // Montgomery accumulator
  logic [cnt_w-1:0]  cnt_q; // iterations completed
  logic [cnt_w-1:0]  n_q;   // iterations required for this operation

  logic [cnt_w-1:0]  n_sel;
  int unsigned       words_bits;
  logic [s_w-1:0]    s_add;
  logic [s_w-1:0]    s_odd;
  logic [s_w-1:0]    s_next;
  logic              last;

  // Decode requested operand length; zero or oversize lengths mean full width.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    words_bits = int'(num_words) * int'(wordLen);
    n_sel      = full_n;
    if (num_words != '0 && words_bits <= int'(bitLen)) begin
      n_sel = cnt_w'(words_bits);
    end
  end

  // One radix-2 step: add A[i]*B, make S even by adding M, then halve.
  always_comb begin
    s_add  = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    s_odd  = s_add + (s_add[0] ? {2'b00, m_q} : '0);
    s_next = s_odd >> 1;
    last   = (cnt_q == (n_q - cnt_w'(1)));
  end

`ifdef MON_PROD_FINAL_SUB_EN
  // When S >= M the difference is below M, so the low bitLen bits are exact.
  logic [bitLen-1:0] s_sub;
  assign s_sub = s_q[bitLen-1:0] - m_q;
`endif

  // State register; reset has priority over everything.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CALC;
`ifdef MON_PROD_FINAL_SUB_EN
      CALC: if (last) state_d = SUB;
      SUB:  state_d = DONE;
`else
      CALC: if (last) state_d = DONE;
`endif
      DONE: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  // NOTE: these are plain registers, not a memory, so they all take the sync reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
      n_q   <= '0;
      P     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            m_q   <= M;
            n_q   <= n_sel;
            s_q   <= '0;
            cnt_q <= '0;
          end
        end
        CALC: begin
          s_q   <= s_next;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + cnt_w'(1);
`ifndef MON_PROD_FINAL_SUB_EN
          if (last) P <= s_next[bitLen-1:0];
`endif
        end
`ifdef MON_PROD_FINAL_SUB_EN
        SUB: begin
          P <= (s_q >= {2'b00, m_q}) ? s_sub : s_q[bitLen-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

  // Done flag is a pure decode of the state register.
  assign stop = (state_q == DONE);

endmodule

// File: tb/tb_mon_prod.sv
// tb_mon_prod: directed self-checking bench for mon_prod (64-bit, 8-bit words).
module tb_mon_prod;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] A, B, M;
  logic [4:0]  num_words;
  logic        stop;
  logic [63:0] P;

  int checks = 0;
  int errors = 0;

`ifdef MON_PROD_FINAL_SUB_EN
  localparam int lat_extra = 2;
  localparam logic [63:0] p_031 = 64'd1;
`else
  localparam int lat_extra = 1;
  localparam logic [63:0] p_031 = 64'd254;   // unreduced: 254 = 1 + 253
`endif

  mon_prod #(.bitLen(64), .wordLen(8), .countWidth(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .M         (M),
    .num_words (num_words),
    .stop      (stop),
    .P         (P)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch an operation and count edges (sampling edge = 1) until stop is seen.
  // Inputs are scrambled after the sampling edge to show they were captured.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                        input logic [4:0] nw, input bit pulse, output int edges);
    A = a; B = b; M = m; num_words = nw; start = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        if (pulse) start = 1'b0;
        A = ~a; B = ~b; M = 64'd6; num_words = 5'd3;
      end
    end while (!stop && edges < 200);
  endtask

  // Count stop-high samples over a number of edges.
  task automatic count_stop(input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (stop) highs++;
    end
  endtask

  int lat;
  int highs;

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; M = '0; num_words = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stop", {63'd0, stop}, 64'd0);
    check("reset_p", P, 64'd0);
    reset = 1'b0;

    // 216*123*2^-8 mod 253, start held high
    run_op(64'd216, 64'd123, 64'd253, 5'd1, 1'b0, lat);
    check("c031_latency", 64'(lat), 64'(8 + lat_extra));
    check("c031_p", P, p_031);
    count_stop(3, highs);
    check("c031_hold_stop", 64'(highs), 64'd3);
    check("c031_hold_p", P, p_031);
    start = 1'b0;
    @(posedge clk); #1;
    check("c031_drop_stop", {63'd0, stop}, 64'd0);
    check("c031_idle_p", P, p_031);
    count_stop(3, highs);
    check("c031_idle_stop", 64'(highs), 64'd0);

    // zero multiplicand
    run_op(64'd0, 64'd123, 64'd253, 5'd1, 1'b0, lat);
    check("c033_latency", 64'(lat), 64'(8 + lat_extra));
    check("c033_p", P, 64'd0);
    count_stop(2, highs);
    check("c033_hold_stop", 64'(highs), 64'd2);
    start = 1'b0;
    @(posedge clk); #1;
    check("c033_drop_stop", {63'd0, stop}, 64'd0);
    check("c033_p_kept", P, 64'd0);

    // full width (num_words=0), R = 2^64 == 1 mod 2^64-1
    run_op(64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 1'b1, lat);
    check("c032_latency", 64'(lat), 64'(64 + lat_extra));
    check("c032_p", P, 64'd15);
    @(posedge clk); #1;

    // oversize length (9 words = 72 bits) clamps to full width
    run_op(64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1'b1, lat);
    check("clamp_latency", 64'(lat), 64'(64 + lat_extra));
    check("clamp_p", P, 64'd15);
    @(posedge clk); #1;

    // reset during the fourth CALC cycle aborts with P cleared (P was 15)
    A = 64'd216; B = 64'd123; M = 64'd253; num_words = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("c034_stop", {63'd0, stop}, 64'd0);
    check("c034_p", P, 64'd0);
    reset = 1'b0;
    count_stop(20, highs);
    check("c034_no_pulse", 64'(highs), 64'd0);
    check("c034_p_idle", P, 64'd0);

    // rerun with a one-cycle start pulse
    run_op(64'd216, 64'd123, 64'd253, 5'd1, 1'b1, lat);
    check("c035_latency", 64'(lat), 64'(8 + lat_extra));
    check("c035_p", P, p_031);
    @(posedge clk); #1;
    check("c035_stop_fall", {63'd0, stop}, 64'd0);
    count_stop(15, highs);
    check("c035_single", 64'(highs), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
